note_ram_sequencer: RTL

//  Sequences the 64x32 note RAM for the guitar recorder: records one note per beat into RAM and plays it back one note per beat.

---
 rtl/note_ram_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/note_ram_sequencer.sv
// Note RAM sequencer: records one note per beat into a 64x32 RAM and
// plays the recording back one note per beat, optionally looping.
module note_ram_sequencer #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              beat,
    input  logic              rec_start,
    input  logic              play_start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [DATA_W-1:0] note_in,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] note_out,
    output logic              note_valid,
    output logic              busy,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   rec_len
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RECORD = 2'b01,
        PLAY   = 2'b10
    } state_t;

    localparam logic [ADDR_W:0]   FULL  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_L = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_P = ADDR_W'(1);

    state_t            st;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              cap_pend;
    logic              last_rd;

    assign last_rd = ({1'b0, rd_ptr} + ONE_L) == rec_len;
    assign state   = st;
    assign busy    = (st != IDLE);

    always_comb begin
        ram_addr = '0;
        unique case (st)
            RECORD:  ram_addr = wr_ptr;
            PLAY:    ram_addr = rd_ptr;
            default: ram_addr = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            st         <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rec_len    <= '0;
            cap_pend   <= 1'b0;
            ram_wren   <= 1'b0;
            ram_wdata  <= '0;
            note_out   <= '0;
            note_valid <= 1'b0;
        end else begin
            note_valid <= 1'b0;
            unique case (st)
                IDLE: begin
                    ram_wren  <= 1'b0;
                    ram_wdata <= '0;
                    cap_pend  <= 1'b0;
                    if (rec_start) begin
                        st      <= RECORD;
                        wr_ptr  <= '0;
                        rec_len <= '0;
                    end else if (play_start && rec_len != '0) begin
                        st     <= PLAY;
                        rd_ptr <= '0;
                    end
                end
                RECORD: begin
                    ram_wren  <= 1'b0;
                    ram_wdata <= '0;
                    // a write in flight always completes, even on stop
                    if (ram_wren) begin
                        wr_ptr  <= wr_ptr + ONE_P;
                        rec_len <= rec_len + ONE_L;
                    end
                    if (stop || (ram_wren && (rec_len + ONE_L) == FULL)) begin
                        st <= IDLE;
                    end else if (beat && !ram_wren) begin
                        ram_wren  <= 1'b1;
                        ram_wdata <= note_in;
                    end
                end
                PLAY: begin
                    cap_pend <= beat && !stop;
                    if (cap_pend) begin
                        note_out   <= ram_q;
                        note_valid <= 1'b1;
                        if (!last_rd) begin
                            rd_ptr <= rd_ptr + ONE_P;
                        end else if (loop_en) begin
                            rd_ptr <= '0;
                        end else begin
                            st <= IDLE;
                        end
                    end
                    if (stop) begin
                        st <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule
